// File: rtl/control.sv
// -----------------------------------------------------------------------------
// control
//
// Main control unit of the pipelined MIPS-style processor. It sits in the
// decode stage. The 6-bit opcode is decoded combinationally into the datapath
// control word. The word is then registered so it lines up with the ID/EX
// pipeline boundary.
//
// Supported opcodes are R-type, lw, sw and beq. Any other opcode decodes to an
// all-zero bubble, so no register or memory write enable is ever asserted.
//
// Ports:
//   clk        in   1  system clock; outputs update on its rising edge
//   reset      in   1  asynchronous, active-high; clears every output
//   instru     in   6  instruction opcode field, bits [31:26]
//   RegDest    out  1  write-register select: 1 = rd, 0 = rt
//   SaltoCond  out  1  conditional branch (beq)
//   LeerMem    out  1  data-memory read enable
//   MemaReg    out  1  write-back select: 1 = memory data, 0 = ALU result
//   ALUOp      out  2  00 add, 01 subtract/compare, 10 use funct, 11 unused
//   EscrMem    out  1  data-memory write enable
//   FuenteALU  out  1  ALU operand B: 1 = sign-extended immediate, 0 = rt
//   EscrReg    out  1  register-file write enable
// -----------------------------------------------------------------------------
module control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] instru,
    output logic       RegDest,
    output logic       SaltoCond,
    output logic       LeerMem,
    output logic       MemaReg,
    output logic [1:0] ALUOp,
    output logic       EscrMem,
    output logic       FuenteALU,
    output logic       EscrReg
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_dest;
        logic       fuente_alu;
        logic       mema_reg;
        logic       escr_reg;
        logic       leer_mem;
        logic       escr_mem;
        logic       salto_cond;
        logic [1:0] alu_op;
    } ctrl_t;

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    // Opcode decode. Fields that are don't-care for an opcode are left at 0.
    // They are never X.
    always_comb begin
        // NOTE: default the whole word first so every path assigns every bit;
        // this keeps the block purely combinational (no latch) and makes the
        // unknown-opcode bubble fall out for free.
        ctrl_d = '0;
        case (instru)
            OP_RTYPE: begin
                ctrl_d.reg_dest = 1'b1;
                ctrl_d.escr_reg = 1'b1;
                ctrl_d.alu_op   = ALU_FUNCT;
            end
            OP_LW: begin
                ctrl_d.fuente_alu = 1'b1;
                ctrl_d.mema_reg   = 1'b1;
                ctrl_d.escr_reg   = 1'b1;
                ctrl_d.leer_mem   = 1'b1;
                ctrl_d.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                ctrl_d.fuente_alu = 1'b1;
                ctrl_d.escr_mem   = 1'b1;
                ctrl_d.alu_op     = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl_d.salto_cond = 1'b1;
                ctrl_d.alu_op     = ALU_SUB;
            end
            default: ctrl_d = '0;
        endcase
    end

    // ID/EX control register. Reset clears it immediately, so no stale
    // enable survives a reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignment for registered state, so every flop
        // samples the pre-edge value regardless of block evaluation order.
        if (reset) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign RegDest   = ctrl_q.reg_dest;
    assign FuenteALU = ctrl_q.fuente_alu;
    assign MemaReg   = ctrl_q.mema_reg;
    assign EscrReg   = ctrl_q.escr_reg;
    assign LeerMem   = ctrl_q.leer_mem;
    assign EscrMem   = ctrl_q.escr_mem;
    assign SaltoCond = ctrl_q.salto_cond;
    assign ALUOp     = ctrl_q.alu_op;

endmodule

// File: tb/tb_control.sv
// -----------------------------------------------------------------------------
// tb_control
//
// Self-checking bench for control. The reference model is the opcode table
// from the decode description, held as a 64-entry array of expected control
// words. Each word is packed as:
//   {RegDest, FuenteALU, MemaReg, EscrReg, LeerMem, EscrMem, SaltoCond, ALUOp}
// The DUT is sampled away from the rising edge.
// -----------------------------------------------------------------------------
module tb_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] instru;
    logic       RegDest, SaltoCond, LeerMem, MemaReg, EscrMem, FuenteALU, EscrReg;
    logic [1:0] ALUOp;

    control dut (
        .clk       (clk),
        .reset     (reset),
        .instru    (instru),
        .RegDest   (RegDest),
        .SaltoCond (SaltoCond),
        .LeerMem   (LeerMem),
        .MemaReg   (MemaReg),
        .ALUOp     (ALUOp),
        .EscrMem   (EscrMem),
        .FuenteALU (FuenteALU),
        .EscrReg   (EscrReg)
    );

    // 100 ns clock period
    always #50 clk = ~clk;

    logic [8:0] obs;
    assign obs = {RegDest, FuenteALU, MemaReg, EscrReg, LeerMem, EscrMem, SaltoCond, ALUOp};

    logic [8:0] exp_tbl [64];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] model(input logic [5:0] op);
        return exp_tbl[op];
    endfunction

    // Drive an opcode after a falling edge; check the decode after the next rising edge.
    task automatic step(input logic [5:0] op, input string tag);
        @(negedge clk);
        instru = op;
        @(posedge clk);
        #1;
        check(tag, obs, model(op));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) exp_tbl[i] = 9'b0;
        exp_tbl[6'b000000] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
        exp_tbl[6'b100011] = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        exp_tbl[6'b101011] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
        exp_tbl[6'b000100] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};

        // Reset held across several edges with an R-type opcode present
        reset  = 1'b1;
        instru = 6'b000000;
        #1;
        check("reset_async", obs, 9'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", obs, 9'b0);

        // Release reset; the first edge loads the R-type decode
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_release_no_edge", obs, 9'b0);
        @(posedge clk);
        #1;
        check("post_release_rtype", obs, 9'b1_0_0_1_0_0_0_10);

        // Directed opcode sequence
        step(6'b000000, "seq_rtype0");
        step(6'b000000, "seq_rtype1");
        step(6'b100011, "seq_lw");
        check("seq_lw_literal", obs, 9'b0_1_1_1_1_0_0_00);
        step(6'b101011, "seq_sw");
        check("seq_sw_literal", obs, 9'b0_1_0_0_0_1_0_00);
        step(6'b000100, "seq_beq");
        check("seq_beq_literal", obs, 9'b0_0_0_0_0_0_1_01);

        // Latency: a mid-cycle change is invisible until the next rising edge
        step(6'b000000, "lat_rtype");
        @(negedge clk);
        #20;
        instru = 6'b100011;
        #1;
        check("lat_hold_rtype", obs, model(6'b000000));
        @(posedge clk);
        #1;
        check("lat_switch_lw", obs, model(6'b100011));

        // Unknown opcodes produce a bubble
        step(6'b111111, "unknown_3f");
        step(6'b001000, "unknown_08");

        // Asynchronous reset pulse between edges while lw is decoded
        step(6'b100011, "areset_pre_lw");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("areset_immediate", obs, 9'b0);
        #10;
        reset = 1'b0;
        #1;
        check("areset_released_no_edge", obs, 9'b0);
        @(posedge clk);
        #1;
        check("areset_restore_lw", obs, model(6'b100011));

        // Sweep every opcode: model agreement, enable exclusivity, no X
        for (int op = 0; op < 64; op++) begin
            step(op[5:0], $sformatf("sweep_%02h", op));
            check($sformatf("excl_rd_wr_%02h", op), {8'b0, LeerMem & EscrMem}, 9'b0);
            check($sformatf("excl_reg_mem_%02h", op), {8'b0, EscrReg & EscrMem}, 9'b0);
        end

        // Randomized stimulus, biased toward legal opcodes, with occasional
        // mid-cycle reset pulses and late opcode changes
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            logic [5:0] op2;
            case ($urandom_range(0, 4))
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                default: op = 6'($urandom_range(0, 63));
            endcase
            @(negedge clk);
            instru = op;
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b1;
                #2;
                check("rand_reset", obs, 9'b0);
                #5;
                reset = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                #20;
                op2 = 6'($urandom_range(0, 63));
                instru = op2;
                op = op2;
            end
            @(posedge clk);
            #1;
            check("rand_decode", obs, model(op));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
